// File: rtl/mux_scan_nbit.sv
// -----------------------------------------------------------------------------
// mux_scan_nbit
//
// Purpose:
//   N-channel registered multiplexer with two operating modes.
//     direct (mode = 0): every edge registers channel `sel` onto data_out.
//                        An out-of-range select yields zero data and sel_err.
//     scan   (mode = 1): a small FSM walks the channels enabled in ch_mask in
//                        ascending, wrapping order. Each channel is presented
//                        with a valid/ready handshake and followed by a
//                        programmable dwell gap before the next capture.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active low
//   data_in    N_CH*WIDTH flattened channels, channel i at [i*WIDTH +: WIDTH]
//   sel        channel select used in direct mode
//   mode       0 = direct, 1 = scan
//   ch_mask    per-channel scan enable
//   dwell      idle edges between an accept and the next scan capture
//   ready_in   downstream accept (scan mode only)
//   data_out   registered selected data
//   ch_out     index of the channel currently held in data_out
//   valid_out  data_out / ch_out valid
//   sel_err    direct-mode select is out of range
// -----------------------------------------------------------------------------
module mux_scan_nbit #(
    parameter int N_CH    = 16,
    parameter int WIDTH   = 16,
    parameter int SEL_W   = 5,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  ready_in,
    output logic [WIDTH-1:0]      data_out,
    output logic [SEL_W-1:0]      ch_out,
    output logic                  valid_out,
    output logic                  sel_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_PRESENT,
        S_DWELL
    } state_t;

    // One extra bit so the range check still works when N_CH == 2**SEL_W.
    localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q,   ptr_d;
    logic [DWELL_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]     data_q,  data_d;
    logic [SEL_W-1:0]     ch_q,    ch_d;
    logic                 valid_q, valid_d;
    logic                 err_q,   err_d;

    logic                 sel_oob;
    logic [WIDTH-1:0]     sel_data;
    logic [WIDTH-1:0]     ptr_data;
    logic [SEL_W-1:0]     first_at_ptr;
    logic [SEL_W-1:0]     first_after_ptr;

    // Channel read by comparing against every constant index, so an
    // out-of-range index simply returns zero instead of slicing past the bus.
    function automatic logic [WIDTH-1:0] pick_channel(
        input logic [N_CH*WIDTH-1:0] bus,
        input logic [SEL_W-1:0]      idx
    );
        logic [WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx == SEL_W'(i)) res = bus[i*WIDTH +: WIDTH];
        end
        return res;
    endfunction

    // Lowest enabled channel at or after `start`, wrapping modulo N_CH.
    // Every enabled channel is scored by its wrapped distance from start and
    // the nearest wins; this is a flat single-cycle search for any N_CH.
    // Returns start itself when the mask is empty (callers check the mask).
    function automatic logic [SEL_W-1:0] first_enabled(
        input logic [N_CH-1:0] mask,
        input int              start
    );
        int best;
        int best_d;
        int d;
        best   = start;
        best_d = N_CH;
        for (int i = 0; i < N_CH; i++) begin
            d = (i >= start) ? (i - start) : (i + N_CH - start);
            if (mask[i] && (d < best_d)) begin
                best_d = d;
                best   = i;
            end
        end
        return SEL_W'(best);
    endfunction

    assign sel_oob         = ({1'b0, sel} >= N_CH_L);
    assign sel_data        = pick_channel(data_in, sel);
    assign ptr_data        = pick_channel(data_in, ptr_q);
    assign first_at_ptr    = first_enabled(ch_mask, int'(ptr_q));
    assign first_after_ptr = first_enabled(ch_mask,
                                 (int'(ptr_q) + 1 >= N_CH) ? 0 : int'(ptr_q) + 1);

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal assigned below gets a default first so no path
        // leaves one unassigned; otherwise a latch would be inferred.
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        err_d   = err_q;

        if (!mode) begin
            // Direct mode: the scan engine is parked, any pending scan
            // presentation is simply overwritten.
            state_d = S_IDLE;
            ptr_d   = '0;
            cnt_d   = '0;
            ch_d    = sel;
            if (sel_oob) begin
                data_d  = '0;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end else begin
                data_d  = sel_data;
                valid_d = 1'b1;
                err_d   = 1'b0;
            end
        end else begin
            err_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    valid_d = 1'b0;
                    if (ch_mask != '0) begin
                        ptr_d   = first_at_ptr;
                        state_d = S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    if (ch_mask == '0) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        data_d  = ptr_data;
                        ch_d    = ptr_q;
                        valid_d = 1'b1;
                        state_d = S_PRESENT;
                    end
                end

                // Outputs hold here regardless of ch_mask / dwell changes;
                // only the handshake moves the FSM on.
                S_PRESENT: begin
                    if (valid_q && ready_in) begin
                        valid_d = 1'b0;
                        cnt_d   = dwell;
                        state_d = S_DWELL;
                    end
                end

                S_DWELL: begin
                    if (ch_mask == '0) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else begin
                        ptr_d   = first_after_ptr;
                        state_d = S_CAPTURE;
                    end
                end

                default: begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_out  = data_q;
    assign ch_out    = ch_q;
    assign valid_out = valid_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_scan_nbit.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_nbit
//
// Directed bench for mux_scan_nbit at its default parameters (16 channels of
// 16 bits). Inputs change 1 time unit after each rising edge and outputs are
// sampled at that same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_mux_scan_nbit;

    localparam int N_CH    = 16;
    localparam int WIDTH   = 16;
    localparam int SEL_W   = 5;
    localparam int DWELL_W = 8;

    logic                  clk;
    logic                  rst;
    logic [N_CH*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]      sel;
    logic                  mode;
    logic [N_CH-1:0]       ch_mask;
    logic [DWELL_W-1:0]    dwell;
    logic                  ready_in;
    logic [WIDTH-1:0]      data_out;
    logic [SEL_W-1:0]      ch_out;
    logic                  valid_out;
    logic                  sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    mux_scan_nbit #(
        .N_CH    (N_CH),
        .WIDTH   (WIDTH),
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .sel       (sel),
        .mode      (mode),
        .ch_mask   (ch_mask),
        .dwell     (dwell),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .ch_out    (ch_out),
        .valid_out (valid_out),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, recognisable contents for every channel.
    function automatic logic [WIDTH-1:0] chval(input int i);
        return (i == 5) ? 16'hA5A5 : WIDTH'(16'h1100 + i);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance edge by edge until valid_out is seen; n is the number of edges.
    task automatic wait_valid(input int max_edges, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_out && n < max_edges);
        if (!valid_out) check("wait_valid_timeout", 32'd0, 32'd1);
    endtask

    int n;

    initial begin
        for (int i = 0; i < N_CH; i++) data_in[i*WIDTH +: WIDTH] = chval(i);

        // Reset held two edges with every input nonzero.
        rst      = 1'b0;
        mode     = 1'b0;
        sel      = 5'd5;
        ch_mask  = 16'hFFFF;
        dwell    = 8'd1;
        ready_in = 1'b1;
        tick();
        tick();
        check("rst_data",  32'(data_out),  32'h0);
        check("rst_ch",    32'(ch_out),    32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_err",   32'(sel_err),   32'h0);

        // Direct mode, in-range select, first edge after release.
        rst = 1'b1;
        tick();
        check("dir_data",  32'(data_out),  32'hA5A5);
        check("dir_ch",    32'(ch_out),    32'd5);
        check("dir_valid", 32'(valid_out), 32'h1);
        check("dir_err",   32'(sel_err),   32'h0);

        // Direct mode, out-of-range select.
        sel = 5'd20;
        tick();
        check("oob_data",  32'(data_out),  32'h0);
        check("oob_ch",    32'(ch_out),    32'd20);
        check("oob_valid", 32'(valid_out), 32'h0);
        check("oob_err",   32'(sel_err),   32'h1);

        // Highest legal channel.
        sel = 5'd15;
        tick();
        check("top_data",  32'(data_out),  32'(chval(15)));
        check("top_err",   32'(sel_err),   32'h0);
        check("top_valid", 32'(valid_out), 32'h1);

        // Scan order 0, 3, 15, 0 with dwell 0 and ready held high.
        // sel is left out of range to show scan mode never flags sel_err.
        sel     = 5'd20;
        mode    = 1'b1;
        ch_mask = 16'h8009;
        dwell   = 8'd0;
        tick();
        check("scan_first_valid", 32'(valid_out), 32'h0);
        check("scan_err",         32'(sel_err),   32'h0);
        wait_valid(8, n);
        check("scan_cap_lat", 32'(n),        32'd1);
        check("scan_ch0",     32'(ch_out),   32'd0);
        check("scan_data0",   32'(data_out), 32'(chval(0)));

        tick();
        check("acc0_valid", 32'(valid_out), 32'h0);
        wait_valid(8, n);
        check("gap0", 32'(n),      32'd2);
        check("ch3",  32'(ch_out), 32'd3);
        check("data3", 32'(data_out), 32'(chval(3)));

        tick();
        check("acc3_valid", 32'(valid_out), 32'h0);
        wait_valid(8, n);
        check("gap3", 32'(n),      32'd2);
        check("ch15", 32'(ch_out), 32'd15);

        tick();
        check("acc15_valid", 32'(valid_out), 32'h0);
        wait_valid(8, n);
        check("gap15",   32'(n),      32'd2);
        check("ch0_wrap", 32'(ch_out), 32'd0);

        // Backpressure: ch 0 held for 10 edges while dwell changes underneath.
        ready_in = 1'b0;
        dwell    = 8'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_data",  32'(data_out),  32'(chval(0)));
            check("bp_ch",    32'(ch_out),    32'd0);
            check("bp_valid", 32'(valid_out), 32'h1);
        end

        // Release with dwell 3: valid reasserts 5 edges after the accept.
        ready_in = 1'b1;
        tick();
        check("acc_dw_valid", 32'(valid_out), 32'h0);
        wait_valid(12, n);
        check("gap_dwell3", 32'(n),      32'd5);
        check("dw_ch3",     32'(ch_out), 32'd3);

        // Mask cleared during DWELL drops to IDLE.
        tick();
        check("acc_mc_valid", 32'(valid_out), 32'h0);
        ch_mask = 16'h0000;
        tick();
        check("mc_valid", 32'(valid_out), 32'h0);
        tick();
        tick();
        check("mc_idle_valid", 32'(valid_out), 32'h0);

        // Restored to channel 4 only.
        ch_mask = 16'h0010;
        wait_valid(8, n);
        check("mr_lat",  32'(n),        32'd2);
        check("mr_ch",   32'(ch_out),   32'd4);
        check("mr_data", 32'(data_out), 32'(chval(4)));

        // Reset mid-PRESENT; channels 1 and 6 enabled so that a pointer not
        // cleared by reset would pick 6 instead of 1.
        ready_in = 1'b0;
        ch_mask  = 16'h0042;
        tick();
        check("pre_rst_ch", 32'(ch_out), 32'd4);
        rst = 1'b0;
        tick();
        check("mrst_data",  32'(data_out),  32'h0);
        check("mrst_ch",    32'(ch_out),    32'h0);
        check("mrst_valid", 32'(valid_out), 32'h0);
        check("mrst_err",   32'(sel_err),   32'h0);
        rst = 1'b1;
        tick();
        check("post_rst_valid", 32'(valid_out), 32'h0);
        wait_valid(8, n);
        check("post_rst_lat",  32'(n),        32'd1);
        check("post_rst_ch",   32'(ch_out),   32'd1);
        check("post_rst_data", 32'(data_out), 32'(chval(1)));

        // Mode 1 -> 0 with data pending: direct behaviour on the next edge.
        mode = 1'b0;
        sel  = 5'd2;
        tick();
        check("m10_data",  32'(data_out),  32'(chval(2)));
        check("m10_ch",    32'(ch_out),    32'd2);
        check("m10_valid", 32'(valid_out), 32'h1);
        check("m10_err",   32'(sel_err),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_nbit.md
MUX_SCAN_NBIT -- requirements
Module: mux_scan_nbit

Interface
REQ-001 The block SHALL have parameter N_CH, default 16, meaning number of input channels (2..32).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning bits per channel.
REQ-003 The block SHALL have parameter SEL_W, default 5, meaning select/index width; 2**SEL_W >= N_CH.
REQ-004 The block SHALL have parameter DWELL_W, default 8, meaning dwell counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port data_in, input, N_CH*WIDTH bits: flattened channels; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port sel, input, SEL_W bits: channel select in direct mode.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = direct, 1 = scan.
REQ-010 The block SHALL have port ch_mask, input, N_CH bits: scan enable per channel.
REQ-011 The block SHALL have port dwell, input, DWELL_W bits: idle cycles between an accept and the next scan capture.
REQ-012 The block SHALL have port ready_in, input, 1 bit: downstream accept.
REQ-013 The block SHALL have port data_out, output, WIDTH bits: registered selected data.
REQ-014 The block SHALL have port ch_out, output, SEL_W bits: index of the channel in data_out.
REQ-015 The block SHALL have port valid_out, output, 1 bit: data_out/ch_out valid.
REQ-016 The block SHALL have port sel_err, output, 1 bit: direct-mode sel >= N_CH.

Function
REQ-017 In direct mode, each edge SHALL load data_out <= channel sel and ch_out <= sel, and SHALL set valid_out = 1 and sel_err = 0 (latency 1 cycle; ready_in ignored).
REQ-018 In direct mode with sel >= N_CH, each edge SHALL load data_out = 0, ch_out = sel, valid_out = 0 and sel_err = 1.
REQ-019 Scan mode SHALL use FSM states IDLE, CAPTURE, PRESENT and DWELL; direct mode SHALL hold the FSM in IDLE with ptr = 0.
REQ-020 In IDLE with mode=1, if ch_mask != 0 the FSM SHALL load ptr <= lowest enabled index >= ptr (wrapping) and go to CAPTURE; otherwise it SHALL stay in IDLE with valid_out = 0.
REQ-021 CAPTURE SHALL take one cycle: data_out <= channel ptr, ch_out <= ptr, valid_out <= 1, then go to PRESENT.
REQ-022 In PRESENT, data_out, ch_out and valid_out SHALL stay stable until an edge with valid_out & ready_in, including if ch_mask or dwell change meanwhile.
REQ-023 On the accepting edge, the block SHALL set valid_out <= 0 and cnt <= dwell, and go to DWELL.
REQ-024 In DWELL, each edge with cnt > 0 SHALL decrement cnt; the edge with cnt == 0 SHALL set ptr <= next enabled index after ptr (modulo N_CH, may equal ptr) and go to CAPTURE.
REQ-025 Resulting timing: valid_out SHALL reassert exactly dwell+2 edges after the accepting edge.
REQ-026 If ch_mask == 0 in DWELL or CAPTURE, the FSM SHALL go to IDLE with valid_out = 0 on that edge.
REQ-027 In scan mode, sel_err SHALL be 0.
REQ-028 On mode change 1->0, the next edge SHALL apply direct behaviour; any pending PRESENT data SHALL be dropped.
REQ-029 On mode change 0->1, the FSM SHALL start from IDLE with ptr = 0, and valid_out SHALL be 0 on the first edge.
REQ-030 The next-enabled search SHALL be combinational and complete in one cycle for all N_CH <= 32.

Reset
REQ-031 With rst = 0 at an edge: data_out = 0, ch_out = 0, valid_out = 0, sel_err = 0, FSM = IDLE, ptr = 0, cnt = 0.
REQ-032 Reset SHALL override all inputs in every state, including mid-PRESENT and mid-DWELL.
REQ-033 Operation SHALL resume on the first edge with rst = 1.

Verification
REQ-034 Reset test: rst = 0 for 2 cycles with all inputs nonzero -> data_out = 0, ch_out = 0, valid_out = 0, sel_err = 0.
REQ-035 Direct test: N_CH = 16, mode = 0, channel 5 = 16'hA5A5, sel = 5 -> next edge data_out = A5A5, ch_out = 5, valid_out = 1; then sel = 20 -> data_out = 0, sel_err = 1, valid_out = 0.
REQ-036 Scan order test: ch_mask = 16'h8009, dwell = 0, ready_in = 1 -> ch_out sequence 0, 3, 15, 0; valid_out reasserts 2 edges after each accept.
REQ-037 Backpressure/dwell test: ready_in = 0 for 10 cycles -> data_out/ch_out stable and valid_out = 1; then dwell = 3 with ready_in = 1 -> valid_out reasserts 5 edges after the accept.
REQ-038 Mask-clear test: ch_mask -> 0 during DWELL -> IDLE, valid_out = 0; ch_mask restored to 16'h0010 -> ch_out = 4, valid_out = 1.
REQ-039 Mid-operation reset test: rst = 0 during PRESENT -> all outputs 0 next edge; after release in scan mode, the first capture is the lowest enabled channel.
